// File: rtl/audio_pkg.sv
// audio_pkg: shared constants, sample type and the saturation
// helper used by the I2S output path.
package audio_pkg;

   localparam int I2S_SLOT_BITS  = 32;
   localparam int I2S_FRAME_BITS = 64;
   localparam int SAMPLE_WIDTH   = 16;

   typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;

   // clamp a signed 32-bit value into the signed 16-bit range
   function automatic sample_t sat16(input logic signed [31:0] x);
      sample_t r;
      if (x > 32'sd32767)
         r = 16'sh7FFF;
      else if (x < -32'sd32768)
         r = 16'sh8000;
      else
         r = x[15:0];
      return r;
   endfunction

endpackage

// File: rtl/audio_i2s_tx_sample_fifo.sv
// sample_fifo: small synchronous FIFO holding scaled samples.
// A push on a full FIFO is accepted only when a pop frees a slot.
module sample_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 16
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         push_data,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_q;
   logic [AW-1:0]    rd_q;
   logic [AW:0]      cnt_q;
   logic             do_push;
   logic             do_pop;

   assign empty    = (cnt_q == '0);
   assign full     = (cnt_q == (AW+1)'(DEPTH));
   assign count    = cnt_q;
   assign pop_data = mem[rd_q];
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);

   // storage array, written on every accepted push
   always_ff @(posedge clk_in) begin
      if (do_push)
         mem[wr_q] <= push_data;
   end

   // pointers and occupancy
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push)
            wr_q <= wr_q + AW'(1);
         if (do_pop)
            rd_q <= rd_q + AW'(1);
         unique case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
            2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx: scales PSOLA words to 16 bits, buffers them and
// plays each one as a mono I2S frame (same sample in both slots).
module audio_i2s_tx
   import audio_pkg::*;
#(
   parameter int CLK_DIV    = 4,
   parameter int FIFO_DEPTH = 8,
   parameter int SHIFT      = 8
) (
   input  logic                          clk_in,
   input  logic                          rst_in,
   input  logic [31:0]                   audio_in,
   input  logic                          audio_valid_in,
   output logic                          sclk_out,
   output logic                          ws_out,
   output logic                          sd_out,
   output logic                          sample_req_out,
   output logic                          underrun_out,
   output logic                          overflow_out,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out
);

   localparam int DW = $clog2(CLK_DIV);
   localparam int BW = $clog2(I2S_FRAME_BITS);

   logic [DW-1:0]      div_q;
   logic [BW-1:0]      bit_idx_q;
   logic [BW-1:0]      bit_nxt;
   logic [4:0]         k_nxt;
   sample_t            word_q;
   sample_t            fifo_dout;
   sample_t            push_data;
   logic signed [31:0] shifted;
   logic               div_wrap;
   logic               fall_evt;
   logic               frame_evt;
   logic               fifo_full;
   logic               fifo_empty;
   logic               pop;
   logic               sd_nxt;

   assign shifted   = $signed(audio_in) >>> SHIFT;
   assign push_data = sat16(shifted);
   assign div_wrap  = (div_q == DW'(CLK_DIV - 1));
   assign fall_evt  = div_wrap && sclk_out;
   assign bit_nxt   = bit_idx_q + BW'(1);
   assign k_nxt     = bit_nxt[4:0];
   assign frame_evt = fall_evt && (bit_nxt == '0);
   assign pop       = frame_evt && !fifo_empty;

   sample_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (SAMPLE_WIDTH)
   ) u_fifo (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .push      (audio_valid_in),
      .pop       (pop),
      .push_data (push_data),
      .pop_data  (fifo_dout),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count_out)
   );

   // slot bit k carries word[16-k] for k=1..16, one bclk after ws
   always_comb begin
      sd_nxt = 1'b0;
      if (k_nxt >= 5'd1 && k_nxt <= 5'd16)
         sd_nxt = word_q[4'(5'd16 - k_nxt)];
   end

   // bit clock divider
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         div_q    <= '0;
         sclk_out <= 1'b0;
      end else if (div_wrap) begin
         div_q    <= '0;
         sclk_out <= ~sclk_out;
      end else begin
         div_q <= div_q + DW'(1);
      end
   end

   // serializer, frame sequencing and status pulses
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         bit_idx_q      <= BW'(I2S_FRAME_BITS - 1);
         ws_out         <= 1'b0;
         sd_out         <= 1'b0;
         word_q         <= '0;
         sample_req_out <= 1'b0;
         underrun_out   <= 1'b0;
         overflow_out   <= 1'b0;
      end else begin
         sample_req_out <= frame_evt;
         underrun_out   <= frame_evt && fifo_empty;
         overflow_out   <= audio_valid_in && fifo_full && !pop;
         if (fall_evt) begin
            bit_idx_q <= bit_nxt;
            ws_out    <= (bit_nxt >= BW'(I2S_SLOT_BITS));
            sd_out    <= sd_nxt;
         end
         if (frame_evt)
            word_q <= fifo_empty ? '0 : fifo_dout;
      end
   end

endmodule

// File: tb/tb_audio_i2s_tx.sv
// tb_audio_i2s_tx: cycle-level reference model of the I2S output
// path, directed scenarios plus randomized pushes.
module tb_audio_i2s_tx;

   localparam int CLK_DIV    = 4;
   localparam int FIFO_DEPTH = 8;
   localparam int SHIFT      = 8;
   localparam int BCLK       = 2 * CLK_DIV;
   localparam int FRAME      = 64 * BCLK;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic [31:0] audio_in;
   logic        audio_valid_in;
   logic        sclk_out;
   logic        ws_out;
   logic        sd_out;
   logic        sample_req_out;
   logic        underrun_out;
   logic        overflow_out;
   logic [3:0]  fifo_count_out;

   int n_err = 0;
   int n_chk = 0;

   int          t;
   logic [15:0] mq[$];
   logic [15:0] cur;
   logic [15:0] rx_sh;
   logic [15:0] rx_l[$];
   logic [15:0] rx_r[$];

   audio_i2s_tx #(
      .CLK_DIV    (CLK_DIV),
      .FIFO_DEPTH (FIFO_DEPTH),
      .SHIFT      (SHIFT)
   ) dut (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .audio_in       (audio_in),
      .audio_valid_in (audio_valid_in),
      .sclk_out       (sclk_out),
      .ws_out         (ws_out),
      .sd_out         (sd_out),
      .sample_req_out (sample_req_out),
      .underrun_out   (underrun_out),
      .overflow_out   (overflow_out),
      .fifo_count_out (fifo_count_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h (t=%0d)", tag, got, exp, t);
      end
   endtask

   // floor(x / 2^SHIFT), then clamp to signed 16-bit
   function automatic logic [15:0] sat_ref(input logic [31:0] x);
      longint v;
      longint d;
      longint q;
      v = longint'($signed(x));
      d = longint'(1) << SHIFT;
      q = v / d;
      if (v < 0 && (v % d) != 0)
         q = q - 1;
      if (q > 32767)
         q = 32767;
      if (q < -32768)
         q = -32768;
      return q[15:0];
   endfunction

   function automatic bit is_bnd(input int tt);
      return (tt > 0) && (tt % BCLK == 0) && (((tt / BCLK) - 1) % 64 == 0);
   endfunction

   task automatic tick();
      logic ovf_e;
      logic und_e;
      logic req_e;
      logic ws_e;
      logic sd_e;
      int   n_ev;
      int   idx;
      int   k;
      @(posedge clk_in);
      ovf_e = 1'b0;
      und_e = 1'b0;
      req_e = 1'b0;
      if (rst_in) begin
         t = 0;
         mq.delete();
         cur = '0;
      end else begin
         t++;
         if (is_bnd(t)) begin
            req_e = 1'b1;
            if (mq.size() == 0) begin
               und_e = 1'b1;
               cur   = '0;
            end else begin
               cur = mq.pop_front();
            end
         end
         if (audio_valid_in) begin
            if (mq.size() < FIFO_DEPTH)
               mq.push_back(sat_ref(audio_in));
            else
               ovf_e = 1'b1;
         end
      end
      #1;
      n_ev = t / BCLK;
      ws_e = 1'b0;
      sd_e = 1'b0;
      idx  = 63;
      if (n_ev > 0) begin
         idx  = (n_ev - 1) % 64;
         k    = idx % 32;
         ws_e = (idx >= 32);
         if (k >= 1 && k <= 16)
            sd_e = cur[16 - k];
      end
      chk("sclk", sclk_out, 32'((t / CLK_DIV) % 2));
      chk("ws", ws_out, 32'(ws_e));
      chk("sd", sd_out, 32'(sd_e));
      chk("req", sample_req_out, 32'(req_e));
      chk("underrun", underrun_out, 32'(und_e));
      chk("overflow", overflow_out, 32'(ovf_e));
      chk("count", fifo_count_out, 32'(mq.size()));
      if (t > 0 && t % BCLK == 0) begin
         k = idx % 32;
         if (k >= 1 && k <= 16) begin
            rx_sh = {rx_sh[14:0], sd_out};
            if (k == 16) begin
               if (idx < 32)
                  rx_l.push_back(rx_sh);
               else
                  rx_r.push_back(rx_sh);
            end
         end
      end
   endtask

   task automatic wait_pre_bnd();
      int guard;
      guard = 0;
      while (!is_bnd(t + 1) && guard < FRAME + 16) begin
         tick();
         guard++;
      end
      if (!is_bnd(t + 1))
         chk("bnd_timeout", 32'd1, 32'd0);
   endtask

   task automatic push(input logic [31:0] v);
      audio_in       = v;
      audio_valid_in = 1'b1;
      tick();
      audio_valid_in = 1'b0;
   endtask

   // go through the next boundary, then capture n full frames
   task automatic run_frames(input int n);
      wait_pre_bnd();
      tick();
      rx_l.delete();
      rx_r.delete();
      repeat (n * FRAME - 16) tick();
      chk("rx_l_n", 32'(rx_l.size()), 32'(n));
      chk("rx_r_n", 32'(rx_r.size()), 32'(n));
   endtask

   task automatic chk_frame(input int i, input logic [15:0] exp);
      if (i < rx_l.size() && i < rx_r.size()) begin
         chk($sformatf("left%0d", i), rx_l[i], exp);
         chk($sformatf("right%0d", i), rx_r[i], exp);
      end else begin
         chk($sformatf("frame%0d_missing", i), 32'd1, 32'd0);
      end
   endtask

   logic [31:0] sat_in [4];
   logic [15:0] sat_out[4];

   initial begin
      t              = 0;
      cur            = '0;
      rx_sh          = '0;
      rst_in         = 1'b1;
      audio_in       = '0;
      audio_valid_in = 1'b0;
      sat_in  = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FF00, 32'h0000_00FF};
      sat_out = '{16'h7FFF, 16'h8000, 16'hFFFF, 16'h0000};

      repeat (3) tick();
      chk("rst_count", fifo_count_out, 32'd0);
      chk("rst_sclk", sclk_out, 32'd0);
      rst_in = 1'b0;

      // idle: underrun every frame, silent data
      for (int i = 0; i < 2 * FRAME + 40; i++) begin
         tick();
         if (t == 8)
            chk("first_underrun", underrun_out, 32'd1);
         if (t == 8 + FRAME)
            chk("second_req", sample_req_out, 32'd1);
      end

      // single word in both slots
      wait_pre_bnd();
      tick();
      push(32'h0012_3400);
      chk("t2_count", fifo_count_out, 32'd1);
      run_frames(1);
      chk_frame(0, 16'h1234);

      // saturation corners
      wait_pre_bnd();
      tick();
      for (int i = 0; i < 4; i++)
         push(sat_in[i]);
      run_frames(4);
      for (int i = 0; i < 4; i++)
         chk_frame(i, sat_out[i]);

      // overflow on the ninth back-to-back push
      wait_pre_bnd();
      tick();
      repeat (4) tick();
      for (int i = 1; i <= 9; i++)
         push(32'(i) << 8);
      chk("ovf_pulse", overflow_out, 32'd1);
      chk("ovf_count", fifo_count_out, 32'd8);
      run_frames(9);
      for (int i = 0; i < 9; i++)
         chk_frame(i, (i < 8) ? 16'(i + 1) : 16'h0000);

      // push into an empty FIFO on the boundary cycle
      wait_pre_bnd();
      push(32'h0005_5500);
      chk("simul_underrun", underrun_out, 32'd1);
      chk("simul_count", fifo_count_out, 32'd1);
      rx_l.delete();
      rx_r.delete();
      repeat (2 * FRAME - 16) tick();
      chk_frame(0, 16'h0000);
      chk_frame(1, 16'h0555);

      // reset mid-frame with words queued
      wait_pre_bnd();
      tick();
      for (int i = 0; i < 3; i++)
         push(32'h0000_7700 + 32'(i));
      while (!(t % BCLK == 0 && ((t / BCLK) - 1) % 64 == 20) && t < 400)
         tick();
      chk("pre_rst_count", fifo_count_out, 32'd3);
      rst_in = 1'b1;
      tick();
      chk("mid_rst_sclk", sclk_out, 32'd0);
      chk("mid_rst_ws", ws_out, 32'd0);
      chk("mid_rst_count", fifo_count_out, 32'd0);
      rst_in = 1'b0;
      repeat (8) tick();
      chk("post_rst_underrun", underrun_out, 32'd1);

      // randomized pushes against the model
      for (int i = 0; i < 6000; i++) begin
         logic [31:0] r;
         r              = $urandom;
         audio_in       = 32'($signed(r) >>> $urandom_range(0, 24));
         audio_valid_in = ($urandom_range(0, 79) == 0);
         tick();
      end
      audio_valid_in = 1'b0;
      repeat (20) tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
